seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver.sv | 177 +++++++++++++++++
 tb/tb_seg_scan_driver.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Two-digit multiplexed seven-segment driver for 4x4 keypad codes.
// Alternates digits with blanking gaps so two anodes are never low together.
module seg_scan_driver #(
   parameter int unsigned REFRESH_CYCLES = 24000,
   parameter int unsigned DEAD_CYCLES    = 240
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [8:0] seg0,
   input  logic [8:0] seg1,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic [1:0] code_err
);

   localparam int unsigned MAX_LEN =
      (REFRESH_CYCLES > DEAD_CYCLES) ? REFRESH_CYCLES : DEAD_CYCLES;
   localparam int unsigned CW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [CW-1:0] REF_LAST  = CW'(REFRESH_CYCLES - 1);
   localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
   localparam logic [6:0] SEG_OFF  = 7'b1111111;
   localparam logic [6:0] SEG_DASH = 7'b0111111;

   typedef enum logic [1:0] {
      BLANK0,
      DIG0,
      BLANK1,
      DIG1
   } state_t;

   state_t        st_q, st_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [8:0]    sh0_q, sh0_d;
   logic [8:0]    sh1_q, sh1_d;
   logic [6:0]    seg_q, seg_d;
   logic [1:0]    an_q, an_d;
   logic [1:0]    err_q, err_d;

   logic [8:0] cap_code;
   logic       cap_ok;
   logic [6:0] cap_glyph;

   function automatic logic [1:0] bit_idx(input logic [3:0] v);
      case (v)
         4'b0010: bit_idx = 2'd1;
         4'b0100: bit_idx = 2'd2;
         4'b1000: bit_idx = 2'd3;
         default: bit_idx = 2'd0;
      endcase
   endfunction

   function automatic logic [3:0] key_hex(input logic [3:0] rc);
      case (rc)
         4'h0: key_hex = 4'h1;
         4'h1: key_hex = 4'h2;
         4'h2: key_hex = 4'h3;
         4'h3: key_hex = 4'hA;
         4'h4: key_hex = 4'h4;
         4'h5: key_hex = 4'h5;
         4'h6: key_hex = 4'h6;
         4'h7: key_hex = 4'hB;
         4'h8: key_hex = 4'h7;
         4'h9: key_hex = 4'h8;
         4'hA: key_hex = 4'h9;
         4'hB: key_hex = 4'hC;
         4'hC: key_hex = 4'hE;
         4'hD: key_hex = 4'h0;
         4'hE: key_hex = 4'hF;
         default: key_hex = 4'hD;
      endcase
   endfunction

   function automatic logic [6:0] glyph(input logic [3:0] h);
      case (h)
         4'h0: glyph = 7'b1000000;
         4'h1: glyph = 7'b1111001;
         4'h2: glyph = 7'b0100100;
         4'h3: glyph = 7'b0110000;
         4'h4: glyph = 7'b0011001;
         4'h5: glyph = 7'b0010010;
         4'h6: glyph = 7'b0000010;
         4'h7: glyph = 7'b1111000;
         4'h8: glyph = 7'b0000000;
         4'h9: glyph = 7'b0010000;
         4'hA: glyph = 7'b0001000;
         4'hB: glyph = 7'b0000011;
         4'hC: glyph = 7'b1000110;
         4'hD: glyph = 7'b0100001;
         4'hE: glyph = 7'b0000110;
         default: glyph = 7'b0001110;
      endcase
   endfunction

   // Decode whatever the active blank state is about to latch.
   always_comb begin
      cap_code  = (st_q == BLANK1) ? sh1_d : sh0_d;
      cap_ok    = $onehot(cap_code[7:4]) && $onehot(cap_code[3:0]);
      cap_glyph = SEG_DASH;
      if (cap_ok) begin
         cap_glyph = glyph(key_hex({bit_idx(cap_code[3:0]),
                                    bit_idx(cap_code[7:4])}));
      end
   end

   always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q + CW'(1);
      sh0_d = sh0_q;
      sh1_d = sh1_q;
      seg_d = seg_q;
      an_d  = an_q;
      err_d = err_q;
      unique case (st_q)
         BLANK0: begin
            sh0_d = (cnt_q == DEAD_LAST) ? seg0 : sh0_q;
            if (cnt_q == DEAD_LAST) begin
               st_d     = DIG0;
               cnt_d    = '0;
               an_d     = seg0[8] ? 2'b10 : 2'b11;
               seg_d    = seg0[8] ? cap_glyph : SEG_OFF;
               err_d[0] = seg0[8] & ~cap_ok;
            end
         end
         DIG0: begin
            if (cnt_q == REF_LAST) begin
               st_d  = BLANK1;
               cnt_d = '0;
               an_d  = 2'b11;
               seg_d = SEG_OFF;
            end
         end
         BLANK1: begin
            sh1_d = (cnt_q == DEAD_LAST) ? seg1 : sh1_q;
            if (cnt_q == DEAD_LAST) begin
               st_d     = DIG1;
               cnt_d    = '0;
               an_d     = seg1[8] ? 2'b01 : 2'b11;
               seg_d    = seg1[8] ? cap_glyph : SEG_OFF;
               err_d[1] = seg1[8] & ~cap_ok;
            end
         end
         default: begin
            if (cnt_q == REF_LAST) begin
               st_d  = BLANK0;
               cnt_d = '0;
               an_d  = 2'b11;
               seg_d = SEG_OFF;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         st_q  <= BLANK0;
         cnt_q <= '0;
         sh0_q <= '0;
         sh1_q <= '0;
         seg_q <= SEG_OFF;
         an_q  <= 2'b11;
         err_q <= 2'b00;
      end else begin
         st_q  <= st_d;
         cnt_q <= cnt_d;
         sh0_q <= sh0_d;
         sh1_q <= sh1_d;
         seg_q <= seg_d;
         an_q  <= an_d;
         err_q <= err_d;
      end
   end

   assign seg      = seg_q;
   assign an       = an_q;
   assign code_err = err_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized bench for seg_scan_driver against a scan-position model.
// The model tracks position within the 2*(R+D) scan period arithmetically.
module tb_seg_scan_driver;

   localparam int R = 8;
   localparam int D = 2;
   localparam int P = 2 * (R + D);

   logic       clk = 1'b0;
   logic       reset;
   logic [8:0] seg0, seg1;
   logic [6:0] seg;
   logic [1:0] an, code_err;

   always #5 clk = ~clk;

   seg_scan_driver #(
      .REFRESH_CYCLES(R),
      .DEAD_CYCLES(D)
   ) dut (
      .clk(clk),
      .reset(reset),
      .seg0(seg0),
      .seg1(seg1),
      .seg(seg),
      .an(an),
      .code_err(code_err)
   );

   int checks = 0;
   int failures = 0;
   int k = 0;
   int gap = 0;
   logic [6:0] e_seg = 7'h7f;
   logic [1:0] e_an = 2'b11;
   logic [1:0] e_err = 2'b00;
   logic [1:0] prev_an = 2'b11;

   int key_of [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
   logic [6:0] glyph [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int hot_pos(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return 0;
   endfunction

   task automatic show(input int n, input logic [8:0] c);
      bit ok;
      e_an = 2'b11;
      e_seg = 7'h7f;
      e_err[n] = 1'b0;
      if (c[8]) begin
         ok = ($countones(c[7:4]) == 1) && ($countones(c[3:0]) == 1);
         e_an[n] = 1'b0;
         e_seg = ok ? glyph[key_of[hot_pos(c[3:0]) * 4 + hot_pos(c[7:4])]]
                    : 7'b0111111;
         e_err[n] = !ok;
      end
   endtask

   task automatic model();
      if (!reset) begin
         k = 0;
         e_an = 2'b11;
         e_seg = 7'h7f;
         e_err = 2'b00;
      end else begin
         k = (k + 1) % P;
         if (k == D) show(0, seg0);
         else if (k == 2 * D + R) show(1, seg1);
         else if (k == D + R || k == 0) begin
            e_an = 2'b11;
            e_seg = 7'h7f;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model();
      @(negedge clk);
      check("seg", 32'(seg), 32'(e_seg));
      check("an", 32'(an), 32'(e_an));
      check("code_err", 32'(code_err), 32'(e_err));
      check("an_both_low", 32'(an == 2'b00), 32'd0);
      if (an != 2'b11) begin
         if (prev_an == 2'b11) check("dead_gap", 32'(gap >= D), 32'd1);
         gap = 0;
      end else begin
         gap++;
      end
      prev_an = an;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_k(input int target);
      for (int i = 0; i <= P && k != target; i++) step();
   endtask

   function automatic logic [8:0] rand_code();
      logic [3:0] c, r;
      c = ($urandom % 3 == 0) ? 4'($urandom) : 4'(1 << ($urandom % 4));
      r = ($urandom % 3 == 0) ? 4'($urandom) : 4'(1 << ($urandom % 4));
      return {($urandom % 4) != 0, c, r};
   endfunction

   initial begin
      reset = 1'b0;
      seg0 = '0;
      seg1 = '0;
      run(3);
      seg0 = 9'b1_0001_0001;
      reset = 1'b1;
      run(40);
      seg0 = 9'b1_0010_1000;
      seg1 = 9'b1_1000_0001;
      run(40);
      seg0 = 9'b1_0011_0001;
      run(40);
      seg0 = 9'b1_0001_0001;
      run(40);
      wait_k(D + 3);
      seg0 = 9'b1_0010_0010;
      run(40);
      wait_k(2 * D + R + 2);
      reset = 1'b0;
      step();
      reset = 1'b1;
      run(30);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom % 6 == 0) seg0 = rand_code();
         if ($urandom % 6 == 0) seg1 = rand_code();
         reset = ($urandom % 400) != 0;
         step();
      end
      reset = 1'b1;
      run(P);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
